// File: rtl/pc_ctrl_if.sv
// Fetch-stage PC sequencing bus between the redirect sources and the PC register.
// The master side drives requests and fetch handshake; the slave side (pc_ctrl) drives PC controls.
interface pc_ctrl_if #(
  parameter int unsigned XLEN = 64
);
  logic            fetch_ready;
  logic            branch_valid;
  logic [XLEN-1:0] branch_target;
  logic            trap_req;
  logic [XLEN-1:0] trap_vector;
  logic            dbg_halt_req;
  logic            dbg_resume_req;
  logic            dbg_pc_write;
  logic [XLEN-1:0] dbg_pc_data;

  logic            pc_enable;
  logic [1:0]      pc_sel;
  logic [XLEN-1:0] pc_branch;
  logic [XLEN-1:0] pc_interrupt;
  logic [XLEN-1:0] pc_debug_addr;
  logic            flush;
  logic            halted;

  modport master (
    output fetch_ready, branch_valid, branch_target, trap_req, trap_vector,
           dbg_halt_req, dbg_resume_req, dbg_pc_write, dbg_pc_data,
    input  pc_enable, pc_sel, pc_branch, pc_interrupt, pc_debug_addr,
           flush, halted
  );

  modport slave (
    input  fetch_ready, branch_valid, branch_target, trap_req, trap_vector,
           dbg_halt_req, dbg_resume_req, dbg_pc_write, dbg_pc_data,
    output pc_enable, pc_sel, pc_branch, pc_interrupt, pc_debug_addr,
           flush, halted
  );
endinterface

// File: rtl/pc_ctrl.sv
// Next-PC sequencing controller: captures branch/trap/debug redirects into pending
// registers and applies them to the PC register, with a debug RUN/HALT state machine.
module pc_ctrl #(
  parameter int unsigned XLEN = 64
) (
  input  logic        clk,
  input  logic        reset,
  pc_ctrl_if.slave    bus
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'b00,
    SEL_BRANCH = 2'b01,
    SEL_TRAP   = 2'b10,
    SEL_DEBUG  = 2'b11
  } sel_e;

  state_e          r_state;
  state_e          w_next_state;

  logic            r_br_pend;
  logic            r_tr_pend;
  logic            r_dbg_pend;
  logic            r_resume_pend;
  logic [XLEN-1:0] r_branch;
  logic [XLEN-1:0] r_interrupt;
  logic [XLEN-1:0] r_debug_addr;

  logic            w_enable;
  sel_e            w_sel;
  logic            w_resume_hold;

  logic            w_take_tr;
  logic            w_take_br;
  logic            w_take_dbg;
  logic            w_dbg_wr;
  logic            w_br_accept;

  // Redirect application depends only on registered state and fetch_ready.
  assign w_take_tr   = (r_state == ST_RUN) && bus.fetch_ready && r_tr_pend;
  assign w_take_br   = (r_state == ST_RUN) && bus.fetch_ready && !r_tr_pend && r_br_pend;
  assign w_take_dbg  = (r_state == ST_HALT) && r_dbg_pend;
  assign w_dbg_wr    = (r_state == ST_HALT) && bus.dbg_pc_write;
  assign w_br_accept = bus.branch_valid && !bus.trap_req && !r_tr_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_enable      = 1'b0;
    w_sel         = SEL_SEQ;
    w_resume_hold = r_resume_pend;
    case (r_state)
      ST_RUN: begin
        w_enable = bus.fetch_ready;
        if (r_tr_pend) begin
          w_sel = SEL_TRAP;
        end else if (r_br_pend) begin
          w_sel = SEL_BRANCH;
        end
        if (bus.dbg_halt_req) begin
          w_next_state = ST_HALT;
        end
      end
      ST_HALT: begin
        if (r_dbg_pend) begin
          w_enable = 1'b1;
          w_sel    = SEL_DEBUG;
        end
        // A resume waits until the debug PC write has been applied; a write landing
        // in the resume cycle itself also holds the resume so the write is not stranded.
        if (bus.dbg_resume_req || r_resume_pend) begin
          if (r_dbg_pend || bus.dbg_pc_write) begin
            w_resume_hold = 1'b1;
          end else begin
            w_resume_hold = 1'b0;
            w_next_state  = ST_RUN;
          end
        end
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_br_pend     <= 1'b0;
      r_tr_pend     <= 1'b0;
      r_dbg_pend    <= 1'b0;
      r_resume_pend <= 1'b0;
      r_branch      <= '0;
      r_interrupt   <= '0;
      r_debug_addr  <= '0;
    end else begin
      r_resume_pend <= w_resume_hold;

      if (bus.trap_req) begin
        r_tr_pend   <= 1'b1;
        r_interrupt <= bus.trap_vector;
      end else if (w_take_tr) begin
        r_tr_pend <= 1'b0;
      end

      // A trap or a debug PC write supersedes any pending branch.
      if (bus.trap_req || w_dbg_wr) begin
        r_br_pend <= 1'b0;
      end else if (w_br_accept) begin
        r_br_pend <= 1'b1;
      end else if (w_take_br) begin
        r_br_pend <= 1'b0;
      end

      if (w_br_accept) begin
        r_branch <= bus.branch_target;
      end

      if (w_dbg_wr) begin
        r_dbg_pend   <= 1'b1;
        r_debug_addr <= bus.dbg_pc_data;
      end else if (w_take_dbg) begin
        r_dbg_pend <= 1'b0;
      end
    end
  end

  assign bus.pc_enable     = reset ? 1'b0 : w_enable;
  assign bus.pc_sel        = reset ? SEL_SEQ : w_sel;
  assign bus.flush         = !reset && w_enable && (w_sel != SEL_SEQ);
  assign bus.halted        = !reset && (r_state == ST_HALT);
  assign bus.pc_branch     = r_branch;
  assign bus.pc_interrupt  = r_interrupt;
  assign bus.pc_debug_addr = r_debug_addr;

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Next-PC sequencing controller for the fetch stage. It drives the enable, select and target inputs of the 64-bit program counter register. It arbitrates redirect sources (branch/jump, trap, debug write) against sequential +4 advance, holding redirects pending while fetch is stalled. It also implements a debug halt/resume state machine.

## Interface
Parameters:
- XLEN, 64, address width of all PC/target buses

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- fetch_ready  in  1  fetch accepted current PC; PC may change this cycle
- branch_valid  in  1  one-cycle branch/jump redirect request
- branch_target  in  XLEN  redirect target, sampled when branch_valid=1
- trap_req  in  1  one-cycle trap/interrupt request
- trap_vector  in  XLEN  trap handler address, sampled when trap_req=1
- dbg_halt_req  in  1  debugger halt request
- dbg_resume_req  in  1  debugger resume request
- dbg_pc_write  in  1  debugger PC write, honoured only in HALT
- dbg_pc_data  in  XLEN  debugger PC value, sampled with dbg_pc_write
- pc_enable  out  1  enable to PC register
- pc_sel  out  2  00 = +4, 01 = branch, 10 = trap, 11 = debug address
- pc_branch  out  XLEN  registered pending branch target
- pc_interrupt  out  XLEN  registered pending trap target
- pc_debug_addr  out  XLEN  registered debug PC value
- flush  out  1  redirect applied this cycle (pc_enable=1 and pc_sel≠00)
- halted  out  1  state is HALT

## Operation
- Pending registers: br_pend plus pc_branch, tr_pend plus pc_interrupt, dbg_pend plus pc_debug_addr.
- States: RUN and HALT. Reset state is RUN.
- Capture happens in the cycle of the request; the redirect is applied in a later cycle.
  - trap_req=1 sets tr_pend and loads pc_interrupt, in any state. It clears br_pend.
  - branch_valid=1 with no trap_req and tr_pend=0 sets br_pend and loads pc_branch.
  - branch_valid=1 while a trap is pending or requested is dropped.
  - A new branch while br_pend=1 overwrites the target.
  - dbg_pc_write=1 in HALT sets dbg_pend, loads pc_debug_addr and clears br_pend. In RUN it is ignored.
- RUN outputs, evaluated in priority order:
  - tr_pend: pc_sel=10.
  - Else br_pend: pc_sel=01.
  - Else: pc_sel=00.
  - pc_enable=fetch_ready.
  - A pending flag clears on the edge where it is applied (pc_enable=1).
- HALT outputs: if dbg_pend, pc_enable=1 and pc_sel=11, and dbg_pend clears. Otherwise pc_enable=0 and pc_sel=00. fetch_ready is ignored in HALT.
- Transitions:
  - RUN to HALT on dbg_halt_req. Any redirect applied in that same cycle still completes.
  - HALT to RUN on dbg_resume_req with dbg_pend=0. With dbg_pend=1, resume is deferred one cycle; the request is remembered.
  - dbg_halt_req and dbg_resume_req together: halt wins in RUN, resume wins in HALT.
- tr_pend and br_pend survive HALT and are applied after resume.
- A debug PC write does not clear tr_pend.

## Timing
- Reset values:
  - state RUN; all pending flags 0; pc_branch, pc_interrupt and pc_debug_addr 0.
  - While reset=1: pc_enable=0, pc_sel=00, flush=0, halted=0.
  - Requests in reset cycles are ignored.
- pc_enable, pc_sel and flush are combinational from state, pending flags and fetch_ready. They have no combinational path from branch_valid, trap_req or debug inputs.
- Redirect latency: request at cycle N with fetch_ready=1 gives redirect outputs at N+1, and the PC holds the target after the N+1 edge. Cycle N still issues a +4 if fetch_ready=1.
- Stall: redirect outputs stay asserted with pc_enable=0 until the first fetch_ready=1 cycle.
- Halt latency: halted=1 from the cycle after dbg_halt_req.
- Resume latency: pc_enable can go high the cycle after dbg_resume_req.
- Debug write: applied the cycle after dbg_pc_write.
- Reset asserted mid-stall or mid-HALT clears everything on that edge.

## Test plan
- Sequential: reset, then fetch_ready=1 for 4 cycles. Require pc_enable=1 and pc_sel=00 each cycle; PC reaches 0x10. With fetch_ready=0, require pc_enable=0.
- Branch under stall: branch_valid with 0x8000 at N, fetch_ready=0 for N+1..N+3. Require pc_sel=01, pc_branch=0x8000 and pc_enable=0 through N+3. Raise fetch_ready at N+4: require pc_enable=1 and flush=1, with pc_sel back to 00 at N+5.
- Trap beats branch: same-cycle trap_req (vector 0x100) and branch_valid (0x8000). Require pc_sel=10 and PC=0x100, with no later 01 redirect. A branch raised while the trap is pending is dropped.
- Debug: halt_req gives halted=1 next cycle and pc_enable=0 even with fetch_ready=1. dbg_pc_write of 0x4000 gives pc_sel=11 and pc_enable=1 for one cycle. resume_req gives halted=0 and +4 advance from 0x4000.
- Pending across halt: trap_req at the same cycle as halt_req. Require no trap redirect while halted, then pc_sel=10 in the first RUN cycle after resume.
- Reset mid-operation: reset with br_pend=1 and HALT. Require state RUN, flags 0 and outputs at reset values the next cycle.
